mem_arbiter: RTL

Two-requester arbiter that shares one single-port `memory_unit` between instruction fetch (port 0) and load/store (port 1) of the RISC-V core. Accepts at most one request per cycle via valid/ready handshakes, arbitrates round-robin on collisions, drives the memory's enable, address and data pins, and returns registered per-port responses with backpressure. It sits between the core pipeline front-ends and the memory instance.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 96 +++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response bus between the two core front-ends and the memory arbiter.
// Port 0 is instruction fetch, port 1 is load/store.
interface mem_arbiter_if #(
  parameter int ADDRSIZE = 64,
  parameter int WORDSIZE = 64
);
  logic                req0_valid;
  logic                req0_ready;
  logic                req0_we;
  logic [ADDRSIZE-1:0] req0_addr;
  logic [WORDSIZE-1:0] req0_wdata;
  logic                resp0_valid;
  logic                resp0_ready;
  logic [WORDSIZE-1:0] resp0_rdata;

  logic                req1_valid;
  logic                req1_ready;
  logic                req1_we;
  logic [ADDRSIZE-1:0] req1_addr;
  logic [WORDSIZE-1:0] req1_wdata;
  logic                resp1_valid;
  logic                resp1_ready;
  logic [WORDSIZE-1:0] resp1_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata, resp0_ready,
    input  req1_valid, req1_we, req1_addr, req1_wdata, resp1_ready,
    output req0_ready, resp0_valid, resp0_rdata,
    output req1_ready, resp1_valid, resp1_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata, resp0_ready,
    output req1_valid, req1_we, req1_addr, req1_wdata, resp1_ready,
    input  req0_ready, resp0_valid, resp0_rdata,
    input  req1_ready, resp1_valid, resp1_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch (port 0)
// and load/store (port 1), with one registered outstanding response per port.
module mem_arbiter #(
  parameter int ADDRSIZE = 64,
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                rst,
  mem_arbiter_if.slave        bus,
  output logic                o_mem_wren,
  output logic                o_mem_rden,
  output logic [ADDRSIZE-1:0] o_mem_addr,
  output logic [WORDSIZE-1:0] o_mem_d,
  input  logic [WORDSIZE-1:0] i_mem_q
);

  logic                r_last_grant;
  logic                r_resp0_valid;
  logic                r_resp1_valid;
  logic [WORDSIZE-1:0] r_resp0_rdata;
  logic [WORDSIZE-1:0] r_resp1_rdata;

  logic w_elig0;
  logic w_elig1;
  logic w_gnt0;
  logic w_gnt1;

  // A slot is free when empty or being drained this cycle; reset blocks all grants.
  always_comb begin
    w_elig0 = !rst && bus.req0_valid && (!r_resp0_valid || bus.resp0_ready);
    w_elig1 = !rst && bus.req1_valid && (!r_resp1_valid || bus.resp1_ready);
    w_gnt0  = w_elig0 && (!w_elig1 || r_last_grant);
    w_gnt1  = w_elig1 && (!w_elig0 || !r_last_grant);
  end

  always_comb begin
    o_mem_wren = 1'b0;
    o_mem_rden = 1'b0;
    o_mem_addr = '0;
    o_mem_d    = '0;
    if (w_gnt0) begin
      o_mem_wren = bus.req0_we;
      o_mem_rden = !bus.req0_we;
      o_mem_addr = bus.req0_addr;
      o_mem_d    = bus.req0_wdata;
    end else if (w_gnt1) begin
      o_mem_wren = bus.req1_we;
      o_mem_rden = !bus.req1_we;
      o_mem_addr = bus.req1_addr;
      o_mem_d    = bus.req1_wdata;
    end
  end

  assign bus.req0_ready  = w_gnt0;
  assign bus.req1_ready  = w_gnt1;
  assign bus.resp0_valid = r_resp0_valid;
  assign bus.resp1_valid = r_resp1_valid;
  assign bus.resp0_rdata = r_resp0_rdata;
  assign bus.resp1_rdata = r_resp1_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp0_valid <= 1'b0;
      r_resp0_rdata <= '0;
    end else if (w_gnt0) begin
      r_resp0_valid <= 1'b1;
      r_resp0_rdata <= bus.req0_we ? '0 : i_mem_q;
    end else if (bus.resp0_ready) begin
      r_resp0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp1_valid <= 1'b0;
      r_resp1_rdata <= '0;
    end else if (w_gnt1) begin
      r_resp1_valid <= 1'b1;
      r_resp1_rdata <= bus.req1_we ? '0 : i_mem_q;
    end else if (bus.resp1_ready) begin
      r_resp1_valid <= 1'b0;
    end
  end

  // Reset to 1 so port 0 wins the first collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_gnt0) begin
      r_last_grant <= 1'b0;
    end else if (w_gnt1) begin
      r_last_grant <= 1'b1;
    end
  end

endmodule
